// File: rtl/div_defs.sv
// Shared definitions for the repeated-subtraction divider:
// controller state encoding and state register width.
package div_defs;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SUB   = 3'd2,
        DONE  = 3'd3,
        DZERR = 3'd4
    } state_t;

endpackage

// File: rtl/div_repsub_ctrl.sv
// Controller for the repeated-subtraction divider.
// Sequences load / compare / subtract and raises the completion pulses.
// busy, done and dz_err are decoded from the state register only.
module div_repsub_ctrl
    import div_defs::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic dz,
    input  logic lt,
    output logic ld,
    output logic sub,
    output logic set_err,
    output logic busy,
    output logic done,
    output logic dz_err
);

    state_t state;
    state_t state_next;

    // State register; reset returns the controller to IDLE at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and datapath strobes.
    always_comb begin
        state_next = state;
        ld         = 1'b0;
        sub        = 1'b0;
        set_err    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        dz_err     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ld         = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                // Zero divisor takes priority over the magnitude test.
                if (dz) begin
                    set_err    = 1'b1;
                    state_next = DZERR;
                end else if (lt) begin
                    state_next = DONE;
                end else begin
                    state_next = SUB;
                end
            end
            SUB: begin
                busy       = 1'b1;
                sub        = 1'b1;
                state_next = CHECK;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            DZERR: begin
                done       = 1'b1;
                dz_err     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/div_repsub.sv
// Sequential unsigned divider by repeated subtraction.
// Holds the remainder / divisor / quotient registers, the comparator and
// the subtractor; sequencing is delegated to div_repsub_ctrl.
module div_repsub
    import div_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dz_err
);

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;

    logic ld;
    logic sub;
    logic set_err;
    logic dz;
    logic lt;

    // Unsigned WIDTH-bit comparisons feeding the controller.
    assign dz = (d_reg == '0);
    assign lt = (r_reg < d_reg);

    div_repsub_ctrl u_ctrl (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .dz      (dz),
        .lt      (lt),
        .ld      (ld),
        .sub     (sub),
        .set_err (set_err),
        .busy    (busy),
        .done    (done),
        .dz_err  (dz_err)
    );

    // Datapath registers: load operands, subtract and count, or flag divide-by-zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_reg <= '0;
            d_reg <= '0;
            q_reg <= '0;
        end else if (ld) begin
            r_reg <= dividend;
            d_reg <= divisor;
            q_reg <= '0;
        end else if (set_err) begin
            q_reg <= {WIDTH{1'b1}};
        end else if (sub) begin
            // SUB is only reached with R >= D, so neither operation wraps.
            r_reg <= r_reg - d_reg;
            q_reg <= q_reg + 1'b1;
        end
    end

    assign quotient  = q_reg;
    assign remainder = r_reg;

endmodule
